button_debounce: RTL and testbench
==================================

Name: button_debounce

Overview:
Input-side counterpart of the LED blink output: reads WIDTH raw mechanical button/DIP inputs from board pins and delivers clean levels plus single-cycle press and release events to user logic. Each input gets its own 2-FF synchronizer and debounce FSM. Sits directly behind the top-level pin inputs, in the PLL output clock domain.

Parameters:
WIDTH, 8, number of independent inputs
DEBOUNCE_CYCLES, 20000, consecutive stable cycles required to accept a change (10 ms at 2 MHz); legal range 2..2^20
ACTIVE_LOW, 1, 1 = pin reads 0 when pressed; 0 = pin reads 1 when pressed
LONG_CYCLES, 2000000, hold time for long-press event (used only with the optional feature)

Ports:
clk_i  in  1  system clock (PLL CLK0)
rst_i  in  1  synchronous reset, active-high
btn_n_i  in  WIDTH  raw, asynchronous pin inputs, polarity per ACTIVE_LOW
level_o  out  WIDTH  debounced level, 1 = pressed
press_o  out  WIDTH  1-cycle pulse on accepted press
release_o  out  WIDTH  1-cycle pulse on accepted release
long_o  out  WIDTH  1-cycle long-press pulse (tied 0 without the optional feature)

Behaviour:
- Interface fixed: one clock, clk_i; reset rst_i is synchronous and active-high.
- Reset: level_o, press_o, release_o, long_o = 0; counters = 0; all FSMs in RELEASED; synchronizer FFs loaded with the inactive pin level, so reset causes no spurious press.
- Polarity normalized after sync stage: p = sync ^ ACTIVE_LOW (1 = pressed).
- Per-bit FSM states: RELEASED, DEB_PRESS, PRESSED, DEB_RELEASE.
  - RELEASED: p=1 -> DEB_PRESS, cnt=1.
  - DEB_PRESS: p=0 -> RELEASED, cnt=0 (bounce rejected). p=1 and cnt=DEBOUNCE_CYCLES-1 -> PRESSED; same edge sets level_o=1 and press_o=1 for one cycle. Otherwise cnt++.
  - PRESSED: p=0 -> DEB_RELEASE, cnt=1.
  - DEB_RELEASE: mirror of DEB_PRESS; on acceptance level_o=0 and release_o=1 for one cycle.
- Latency: a clean raw edge held stable produces the event exactly 2+DEBOUNCE_CYCLES clk_i edges later.
- Any glitch shorter than DEBOUNCE_CYCLES produces no event and leaves level_o unchanged.
- Counter width: clog2(DEBOUNCE_CYCLES); the counter never wraps because acceptance occurs at DEBOUNCE_CYCLES-1.
- Bits are fully independent. Simultaneous events on different bits are all reported in the same cycle.
- press_o and release_o are never both 1 on the same bit in the same cycle.
- rst_i mid-debounce or while PRESSED: returns the bit to RELEASED with no release_o pulse. A button still held after reset is re-detected after 2+DEBOUNCE_CYCLES cycles.

Optional Feature:
BUTTON_DEBOUNCE_LONG_PRESS_EN
- Defined: a per-bit hold counter of clog2(LONG_CYCLES) bits.
  - Clears on entry to PRESSED and increments every cycle while in PRESSED or DEB_RELEASE.
  - long_o pulses once when the counter reaches LONG_CYCLES-1 after the press_o cycle, then saturates. No repeat pulse until the next press.
  - A rejected release bounce does not restart the count.
- Undefined: no hold counter is generated and long_o is constant 0.

Decomposition:
- Package button_pkg: FSM state encoding constants (RELEASED=0, DEB_PRESS=1, PRESSED=2, DEB_RELEASE=3) and a clog2 function.
- Sub-module debounce_cell: one synchronizer, FSM and counter(s) for a single bit.
- button_debounce: generate loop instantiating WIDTH debounce_cell instances plus the polarity normalization.

Test Plan (DEBOUNCE_CYCLES=4, LONG_CYCLES=16, WIDTH=8, ACTIVE_LOW=1, 10 MHz clock):
- Reset release with btn_n_i=8'hFF -> all outputs 0 for 50 cycles.
- Bit0 driven to 0 and held -> press_o=8'h01 for exactly 1 cycle, 6 cycles after the edge; level_o=8'h01 from then on.
- Bit3 bouncing 0/1 every 2 cycles for 20 cycles, then held at 1 -> no press_o or release_o; level_o[3] stays 0.
- Bit0 released while bits 1 and 2 pressed on the same edge -> release_o=8'h01 and press_o=8'h06 in the same cycle, 6 cycles later.
- Bit5 pressed, rst_i pulsed 1 cycle while in PRESSED -> level_o=0, no release_o pulse; press_o[5] re-asserts 6 cycles after reset deassertion.
- With BUTTON_DEBOUNCE_LONG_PRESS_EN, bit7 held for 40 cycles -> exactly one long_o=8'h80 pulse, 15 cycles after press_o[7]. Without the macro, long_o stays 8'h00.

Source files
------------

// File: rtl/button_pkg.sv
// Shared definitions for button_debounce: per-bit FSM state encoding and a
// width helper. Optional long-press logic is enabled by BUTTON_DEBOUNCE_LONG_PRESS_EN.
package button_pkg;

    typedef enum logic [1:0] {
        RELEASED    = 2'd0,
        DEB_PRESS   = 2'd1,
        PRESSED     = 2'd2,
        DEB_RELEASE = 2'd3
    } btn_state_e;

    // Bits needed to hold 0..value-1; never narrower than one bit.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        int unsigned remaining;
        result    = 0;
        remaining = (value > 0) ? value - 1 : 0;
        while (remaining != 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return (result == 0) ? 1 : result;
    endfunction

endpackage

// File: rtl/debounce_cell.sv
// Single-bit synchronizer + debounce FSM with registered level/press/release.
// Long-press hold counter is built only when BUTTON_DEBOUNCE_LONG_PRESS_EN is defined.
module debounce_cell
    import button_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 20000,
    parameter int unsigned LONG_CYCLES     = 2000000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic pressed_raw_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic long_o
);

    localparam int unsigned      CNT_W    = clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    btn_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;

    always_comb begin
        sync1_d   = pressed_raw_i;
        sync2_d   = sync1_q;
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        unique case (state_q)
            RELEASED: begin
                if (sync2_q) begin
                    state_d = DEB_PRESS;
                    cnt_d   = CNT_ONE;
                end
            end
            DEB_PRESS: begin
                if (!sync2_q) begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            PRESSED: begin
                if (!sync2_q) begin
                    state_d = DEB_RELEASE;
                    cnt_d   = CNT_ONE;
                end
            end
            DEB_RELEASE: begin
                if (sync2_q) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = RELEASED;
                    cnt_d     = '0;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
        endcase
    end

    // Synchronizer resets to "not pressed" so leaving reset never fakes a press.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            state_q   <= RELEASED;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;

`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
    localparam int unsigned       HOLD_W     = clog2(LONG_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_ONE   = HOLD_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_PULSE = HOLD_W'(LONG_CYCLES - 2);

    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              long_q, long_d;

    // Pulse on the step into LONG_CYCLES-1, then hold there so it cannot repeat.
    always_comb begin
        hold_d = hold_q;
        long_d = 1'b0;
        if (press_d) begin
            hold_d = '0;
        end else if ((state_q == PRESSED || state_q == DEB_RELEASE) && hold_q != HOLD_LAST) begin
            hold_d = hold_q + HOLD_ONE;
            long_d = (hold_q == HOLD_PULSE);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hold_q <= '0;
            long_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
            long_q <= long_d;
        end
    end

    assign long_o = long_q;
`else
    // Always 0; LONG_CYCLES is referenced only so overrides stay legal in this build.
    assign long_o = (LONG_CYCLES == 0) && 1'b0;
`endif

endmodule

// File: rtl/button_debounce.sv
// WIDTH independent debounced button inputs with press/release (and optional
// long-press, BUTTON_DEBOUNCE_LONG_PRESS_EN) single-cycle events.
module button_debounce
    import button_pkg::*;
#(
    parameter int unsigned WIDTH           = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 20000,
    parameter bit          ACTIVE_LOW      = 1'b1,
    parameter int unsigned LONG_CYCLES     = 2000000
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] btn_n_i,
    output logic [WIDTH-1:0] level_o,
    output logic [WIDTH-1:0] press_o,
    output logic [WIDTH-1:0] release_o,
    output logic [WIDTH-1:0] long_o
);

    // Polarity is folded in ahead of the synchronizer; XOR commutes with the
    // flops, so this equals normalizing after sync with an inactive reset value.
    logic [WIDTH-1:0] pressed_raw;
    assign pressed_raw = btn_n_i ^ {WIDTH{ACTIVE_LOW}};

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        debounce_cell #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .LONG_CYCLES    (LONG_CYCLES)
        ) u_cell (
            .clk_i        (clk_i),
            .rst_i        (rst_i),
            .pressed_raw_i(pressed_raw[i]),
            .level_o      (level_o[i]),
            .press_o      (press_o[i]),
            .release_o    (release_o[i]),
            .long_o       (long_o[i])
        );
    end

endmodule

// File: tb/tb_button_debounce.sv
// Bench for button_debounce: directed scenarios plus random bouncing inputs,
// compared every cycle against a run-length behavioural model.
`timescale 1ns/1ps
module tb_button_debounce;

    localparam int unsigned W  = 8;
    localparam int unsigned D  = 4;
    localparam int unsigned L  = 16;
    localparam bit          AL = 1'b1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] btn_n = '1;
    logic [W-1:0] level, press, rel, lng;

    always #50 clk = ~clk;

    button_debounce #(
        .WIDTH(W), .DEBOUNCE_CYCLES(D), .ACTIVE_LOW(AL), .LONG_CYCLES(L)
    ) dut (
        .clk_i(clk), .rst_i(rst), .btn_n_i(btn_n),
        .level_o(level), .press_o(press), .release_o(rel), .long_o(lng)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_i(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: 2-sample delay, then a level flips once the delayed input has
    // differed from it for D consecutive samples.
    logic [W-1:0] m_s1 = '0, m_s2 = '0, m_level = '0;
    logic [W-1:0] m_press = '0, m_rel = '0, m_long = '0;
    int           m_run[W];
    int           m_age[W];
    logic         mp;
    bit           model_live = 1'b0;

    always @(posedge clk) begin
        m_press = '0;
        m_rel   = '0;
        m_long  = '0;
        if (rst) begin
            m_s1    = '0;
            m_s2    = '0;
            m_level = '0;
            for (int i = 0; i < W; i++) begin
                m_run[i] = 0;
                m_age[i] = 0;
            end
        end else begin
            for (int i = 0; i < W; i++) begin
                mp = m_s2[i];
                if (m_level[i]) begin
                    m_age[i]++;
                    if (m_age[i] == L - 1) m_long[i] = 1'b1;
                end
                if (mp != m_level[i]) begin
                    m_run[i]++;
                    if (m_run[i] == D) begin
                        m_level[i] = mp;
                        m_run[i]   = 0;
                        if (mp) begin
                            m_press[i] = 1'b1;
                            m_age[i]   = 0;
                        end else begin
                            m_rel[i] = 1'b1;
                        end
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            m_s2 = m_s1;
            m_s1 = btn_n ^ {W{AL}};
        end
`ifndef BUTTON_DEBOUNCE_LONG_PRESS_EN
        m_long = '0;
`endif
        model_live = 1'b1;
    end

    int cyc = 0;
    int press7_cyc = 0, long7_cyc = 0, long7_cnt = 0;
    int ev3_cnt = 0, rel_cnt = 0;

    always @(negedge clk) begin
        cyc++;
        if (model_live) begin
            chk("level", level, m_level);
            chk("press", press, m_press);
            chk("release", rel, m_rel);
            chk("long", lng, m_long);
            chk("press_and_release", press & rel, '0);
        end
        if (press[7]) press7_cyc = cyc;
        if (lng[7]) begin
            long7_cyc = cyc;
            long7_cnt++;
        end
        if (press[3] || rel[3]) ev3_cnt++;
        if (rel != '0) rel_cnt++;
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_event(input logic [W-1:0] mask, output int k,
                              output logic [W-1:0] pv, output logic [W-1:0] rv);
        k  = -1;
        pv = '0;
        rv = '0;
        for (int n = 1; n <= 20; n++) begin
            tick(1);
            if (((press | rel) & mask) != '0) begin
                k  = n;
                pv = press;
                rv = rel;
                break;
            end
        end
    endtask

    int           k;
    logic [W-1:0] pv, rv;
    int           snap, snap2;
    int           remain[W];

    initial begin
        tick(3);
        rst = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick(1);
            chk("idle_outputs", level | press | rel | lng, '0);
        end

        btn_n = 8'hFE;
        wait_event(8'h01, k, pv, rv);
        chk_i("press0_latency", k, 6);
        chk("press0_value", pv, 8'h01);
        tick(1);
        chk("press0_one_cycle", press, 8'h00);
        chk("press0_level", level, 8'h01);

        snap = ev3_cnt;
        for (int i = 0; i < 10; i++) begin
            btn_n[3] = ~btn_n[3];
            tick(2);
        end
        tick(10);
        chk_i("bounce3_events", ev3_cnt - snap, 0);
        chk("bounce3_level", level, 8'h01);

        btn_n = 8'hF9;
        wait_event(8'h07, k, pv, rv);
        chk_i("simul_latency", k, 6);
        chk("simul_press", pv, 8'h06);
        chk("simul_release", rv, 8'h01);

        btn_n = 8'hD9;
        wait_event(8'h20, k, pv, rv);
        chk_i("press5_latency", k, 6);
        chk("press5_value", pv, 8'h20);
        tick(2);
        snap = rel_cnt;
        rst  = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("reset_level", level, 8'h00);
        wait_event(8'h26, k, pv, rv);
        chk_i("redetect_latency", k, 6);
        chk("redetect_press", pv, 8'h26);
        chk_i("reset_no_release", rel_cnt - snap, 0);
        tick(1);
        chk("redetect_level", level, 8'h26);

        btn_n = 8'hFF;
        tick(12);
        snap  = long7_cnt;
        snap2 = press7_cyc;
        btn_n = 8'h7F;
        tick(40);
        chk_i("press7_seen", (press7_cyc != snap2) ? 1 : 0, 1);
`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
        chk_i("long7_count", long7_cnt - snap, 1);
        chk_i("long7_delay", long7_cyc - press7_cyc, 15);
`else
        chk_i("long7_count", long7_cnt - snap, 0);
`endif
        btn_n = 8'hFF;
        tick(12);

        for (int i = 0; i < W; i++) remain[i] = 1;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < W; i++) begin
                remain[i]--;
                if (remain[i] <= 0) begin
                    btn_n[i]  = ~btn_n[i];
                    remain[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(15, 60))
                                                            : int'($urandom_range(1, 8));
                end
            end
            rst = ($urandom_range(0, 299) == 0);
            tick(1);
        end
        rst   = 1'b0;
        btn_n = '1;
        tick(12);
        chk("final_level", level, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
